// File: rtl/reset_pkg.sv
// rtl/reset_pkg.sv - shared state encoding and parameter limits for the reset sequencer.
package reset_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    GAP,
    RUN,
    SOFT_ARM,
    SOFT_HOLD,
    SOFT_TAIL
  } state_t;

  localparam int NUM_DOMAINS_MIN = 1;
  localparam int NUM_DOMAINS_MAX = 8;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int HOLD_CYCLES_MIN = 1;
  localparam int GAP_CYCLES_MIN  = 0;
  localparam int TAIL_CYCLES_MIN = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchroniser for a single asynchronous level.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  import reset_pkg::*;

  logic [STAGES-1:0] sync_q;

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_ff: STAGES out of range");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL-lock driven staged reset release with masked soft reset.
// Optional lock-loss monitor: RST_LOCK_MONITOR_EN.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int TAIL_CYCLES = 1
) (
  input  logic                   clk_100m,
  input  logic                   rst_n,
  input  logic                   clk_locked,
  input  logic                   step_en,
  input  logic                   soft_reset_req,
  input  logic [NUM_DOMAINS-1:0] soft_reset_mask,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   rst_protect,
  output logic                   busy,
  output logic                   soft_reset_ack
);

  localparam int CNT_MAX = max3(HOLD_CYCLES, GAP_CYCLES, TAIL_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CW-1:0] HOLD_T   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_T    = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] TAIL_T   = CW'(TAIL_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DOMAINS - 1);

  if (NUM_DOMAINS < NUM_DOMAINS_MIN || NUM_DOMAINS > NUM_DOMAINS_MAX) begin : g_bad_num
    $error("reset_sequencer: NUM_DOMAINS out of range");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES out of range");
  end
  if (HOLD_CYCLES < HOLD_CYCLES_MIN) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES out of range");
  end
  if (GAP_CYCLES < GAP_CYCLES_MIN) begin : g_bad_gap
    $error("reset_sequencer: GAP_CYCLES out of range");
  end
  if (TAIL_CYCLES < TAIL_CYCLES_MIN) begin : g_bad_tail
    $error("reset_sequencer: TAIL_CYCLES out of range");
  end

  state_t                 state;
  state_t                 state_next;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          target;
  logic [IW-1:0]          idx;
  logic [NUM_DOMAINS-1:0] mask_q;
  logic [NUM_DOMAINS-1:0] rst_out_q;
  logic                   protect_q;
  logic                   lock_sync;
  logic                   lock_lost;
  logic                   counting;
  logic                   step_done;
  logic                   accept;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk_100m),
    .rst_n(rst_n),
    .d    (clk_locked),
    .q    (lock_sync)
  );

`ifdef RST_LOCK_MONITOR_EN
  assign lock_lost = (state != WAIT_LOCK) && !lock_sync;
`else
  assign lock_lost = 1'b0;
`endif

  // Exits fire on the qualifying step that reaches the count, so cnt never exceeds target-1.
  always_comb begin
    target   = HOLD_T;
    counting = 1'b0;
    case (state)
      HOLD, SOFT_HOLD: begin target = HOLD_T; counting = 1'b1; end
      GAP:             begin target = GAP_T;  counting = 1'b1; end
      SOFT_TAIL:       begin target = TAIL_T; counting = 1'b1; end
      default:         begin target = HOLD_T; counting = 1'b0; end
    endcase
  end

  assign step_done = step_en && counting && ((cnt + 1'b1) == target);
  assign accept    = (state == RUN) && soft_reset_req && (|soft_reset_mask) && !lock_lost;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_LOCK: if (lock_sync) state_next = HOLD;
      HOLD:      if (step_done) state_next = RELEASE;
      RELEASE: begin
        if (idx == LAST_IDX)      state_next = RUN;
        else if (GAP_CYCLES == 0) state_next = RELEASE;
        else                      state_next = GAP;
      end
      GAP:       if (step_done) state_next = RELEASE;
      RUN:       if (accept)    state_next = SOFT_ARM;
      SOFT_ARM:  if (step_en)   state_next = SOFT_HOLD;
      SOFT_HOLD: if (step_done) state_next = SOFT_TAIL;
      SOFT_TAIL: if (step_done) state_next = RUN;
      default:   state_next = WAIT_LOCK;
    endcase
    if (lock_lost) state_next = WAIT_LOCK;
  end

  always_comb begin
    busy           = (state != RUN);
    soft_reset_ack = accept;
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      mask_q    <= '0;
      rst_out_q <= '1;
      protect_q <= 1'b0;
    end else begin
      if (state_next != state) begin
        cnt <= '0;
      end else if (step_en && counting) begin
        cnt <= cnt + 1'b1;
      end

      if (accept) begin
        mask_q    <= soft_reset_mask;
        protect_q <= 1'b1;
      end

      case (state)
        HOLD: if (step_done) idx <= '0;
        RELEASE: begin
          rst_out_q[idx] <= 1'b0;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        SOFT_ARM:  if (step_en)   rst_out_q <= rst_out_q | mask_q;
        SOFT_HOLD: if (step_done) rst_out_q <= rst_out_q & ~mask_q;
        SOFT_TAIL: if (step_done) protect_q <= 1'b0;
        default: ;
      endcase

      // Lock loss overrides whatever the current state was doing this cycle.
      if (lock_lost) begin
        rst_out_q <= '1;
        protect_q <= 1'b0;
        idx       <= '0;
      end
    end
  end

  assign rst_out     = rst_out_q;
  assign rst_protect = protect_q;

endmodule
